reg_value_writer: RTL and testbench

- Writer end of the registry value store: takes an 8-bit character stream and commits it into a value slot as a NUL-terminated UTF-16LE string with a 32-bit byte-size header.
- Our query path reads the size header first, then the data, so this block writes data and terminator first and the size header last (commit ordering).
- Sits between the command/stream front end and the value-store RAM write port.

---
 rtl/reg_value_writer.sv | 180 ++++++++++++++++++
 tb/tb_reg_value_writer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_value_writer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_value_writer
//  Description : Writer end of the registry value store. Packs an 8-bit
//                character stream into a value slot as a NUL-terminated
//                UTF-16LE string, then writes the 32-bit byte-size header
//                last so readers never see a size ahead of its data.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_value_writer #(
  parameter  int KEY_W  = 3,
  parameter  int SLOT_W = 6,
  localparam int ADDR_W = KEY_W + SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              done,
  output logic [1:0]        status
);

  // Largest character count that still leaves room for the terminator.
  localparam int C_MAX_CHARS = (1 << SLOT_W) - 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_TERM  = 3'd2,
    S_SZLO  = 3'd3,
    S_SZHI  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SLOT_W-1:0] r_cnt;
  logic [SLOT_W-1:0] w_cnt_nxt;
  logic [KEY_W-1:0]  r_key;
  logic [KEY_W-1:0]  w_key_nxt;
  logic              r_ovf;
  logic              w_ovf_nxt;

  logic              w_we;
  logic [SLOT_W-1:0] w_off;
  logic [15:0]       w_wdata;
  logic [31:0]       w_size;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              r_done;
  logic [1:0]        r_status;

  // Byte size of the committed string including its terminator.
  assign w_size = (32'(r_cnt) + 32'd1) << 1;

  assign cmd_ready = (r_state == S_IDLE);
  assign s_ready   = (r_state == S_RECV) || (r_state == S_DRAIN);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign status    = r_status;

  // Control state, character count, latched key and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key   <= w_key_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state decode and the write to be registered at the coming edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_key_nxt   = r_key;
    w_ovf_nxt   = r_ovf;
    w_we        = 1'b0;
    w_off       = '0;
    w_wdata     = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_key_nxt   = cmd_key;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (s_valid) begin
          if ((s_data != 8'h00) && (r_cnt == C_MAX_CHARS[SLOT_W-1:0])) begin
            // No room left: nothing more is written for this command.
            w_ovf_nxt   = 1'b1;
            w_state_nxt = s_last ? S_DONE : S_DRAIN;
          end else begin
            // NUL beats are dropped; everything else lands after the header.
            if (s_data != 8'h00) begin
              w_we      = 1'b1;
              w_off     = r_cnt + SLOT_W'(2);
              w_wdata   = {8'h00, s_data};
              w_cnt_nxt = r_cnt + SLOT_W'(1);
            end
            if (s_last) begin
              w_state_nxt = S_TERM;
            end
          end
        end
      end
      S_TERM: begin
        w_we        = 1'b1;
        w_off       = r_cnt + SLOT_W'(2);
        w_wdata     = 16'h0000;
        w_state_nxt = S_SZLO;
      end
      S_SZLO: begin
        w_we        = 1'b1;
        w_off       = SLOT_W'(0);
        w_wdata     = w_size[15:0];
        w_state_nxt = S_SZHI;
      end
      S_SZHI: begin
        w_we        = 1'b1;
        w_off       = SLOT_W'(1);
        w_wdata     = w_size[31:16];
        w_state_nxt = S_DONE;
      end
      S_DRAIN: begin
        if (s_valid && s_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered RAM write port and completion pulse; reset cancels a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
      r_done      <= 1'b0;
      r_status    <= 2'b00;
    end else begin
      r_mem_we <= w_we;
      if (w_we) begin
        r_mem_addr  <= {r_key, w_off};
        r_mem_wdata <= w_wdata;
      end
      r_done   <= (r_state == S_DONE);
      r_status <= (r_state == S_DONE) ? {1'b0, r_ovf} : 2'b00;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_value_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_value_writer
//  Description : Scoreboard bench for reg_value_writer. The driver predicts
//                every RAM write and completion from the string contents and
//                queues them; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_value_writer;

  localparam int KEY_W  = 3;
  localparam int SLOT_W = 6;
  localparam int ADDR_W = KEY_W + SLOT_W;
  localparam int MAXC   = (1 << SLOT_W) - 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [KEY_W-1:0]  cmd_key = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [7:0]        s_data = 8'h00;
  logic              s_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              done;
  logic [1:0]        status;

  reg_value_writer #(.KEY_W(KEY_W), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .status(status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    int                cyc;
  } wr_t;

  typedef struct {
    logic [1:0] st;
    int         cyc;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input int key, input int off);
    return ADDR_W'((key << SLOT_W) + off);
  endfunction

  // Monitor: every write strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_wdata);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_data", 32'(mem_wdata), 32'(w.data));
          chk("wr_cycle", cyc, w.cyc);
        end
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done status %0b expected no done", status);
        end else begin
          d = dq.pop_front();
          chk("done_status", 32'(status), 32'(d.st));
          if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
          chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
        end
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cmd_ready_timeout: got cmd_ready %0b expected 1", cmd_ready);
    end
  endtask

  // Issue one command and its stream; predict results from the string itself.
  task automatic run_tx(input int key, input logic [7:0] ch[$], input int gap_max);
    int n;
    bit ovf;
    int acc;
    int sz;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_key   = KEY_W'(key);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n   = 0;
    ovf = 1'b0;
    acc = 0;
    for (int i = 0; i < ch.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = ch[i];
      s_last  = (i == ch.size() - 1);
      acc     = cyc + 1;
      if (!ovf && ch[i] != 8'h00) begin
        if (n == MAXC) ovf = 1'b1;
        else begin
          wq.push_back('{mk_addr(key, n + 2), {8'h00, ch[i]}, acc});
          n++;
        end
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (ovf) begin
      dq.push_back('{2'b01, -1});
    end else begin
      sz = 2 * (n + 1);
      wq.push_back('{mk_addr(key, n + 2), 16'h0000, acc + 1});
      wq.push_back('{mk_addr(key, 0), 16'(sz), acc + 2});
      wq.push_back('{mk_addr(key, 1), 16'(sz >> 16), acc + 3});
      dq.push_back('{2'b00, acc + 4});
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int k;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 'A','B' to key 2, no gaps.
    q = {8'h41, 8'h42};
    run_tx(2, q, 0);

    // Empty string to key 0.
    q = {8'h00};
    run_tx(0, q, 0);

    // Exactly the maximum length to key 1, with gaps.
    q.delete();
    for (int i = 0; i < MAXC; i++) q.push_back(8'h78);
    run_tx(1, q, 3);

    // Two beyond the maximum: overflow then drain.
    q.delete();
    for (int i = 0; i < MAXC + 2; i++) q.push_back(8'h79);
    run_tx(1, q, 1);

    // Embedded NUL is dropped.
    q = {8'h41, 8'h00, 8'h42};
    run_tx(3, q, 0);

    // Random strings, random keys, occasional NULs and gaps.
    for (int t = 0; t < 25; t++) begin
      q.delete();
      k = $urandom_range(MAXC + 5, 1);
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(7, 0) == 0) q.push_back(8'h00);
        else q.push_back(8'($urandom_range(255, 1)));
      end
      run_tx($urandom_range(7, 0), q, 2);
    end

    // Reset in the middle of a 10-character string.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_key   = 3'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h61 + i);
      s_last  = 1'b0;
      wq.push_back('{mk_addr(5, i + 2), 16'(8'h61 + i), cyc + 1});
      @(posedge clk); #1;
    end
    s_data = 8'h64;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("midrst_mem_we_after", 32'(mem_we), 32'd0);
    q = {8'h51, 8'h52, 8'h53, 8'h54};
    run_tx(5, q, 1);

    k = 0;
    while ((wq.size() != 0 || dq.size() != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("writes_outstanding", 32'(wq.size()), 32'd0);
    chk("dones_outstanding", 32'(dq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
